// File: rtl/pulse_meter_pkg.sv
// -----------------------------------------------------------------------------
// pulse_meter_pkg
//   Shared definitions for the pulse_meter block and its saturating counter.
//
//   Contents:
//     PM_CNT_W_DEFAULT : default counter / measurement width in bits
//     pm_state_t       : measurement FSM states
//                          PM_IDLE - no measurement in progress, waiting for rise
//                          PM_HIGH - input is high, timing the high phase
//                          PM_LOW  - input is low, waiting for the closing rise
// -----------------------------------------------------------------------------
package pulse_meter_pkg;

    localparam int PM_CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        PM_IDLE = 2'd0,
        PM_HIGH = 2'd1,
        PM_LOW  = 2'd2
    } pm_state_t;

endpackage : pulse_meter_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   CNT_W-bit up counter that stops at all-ones instead of wrapping.
//
//   Ports:
//     clk  in   system clock
//     rst  in   synchronous active-high reset (counter -> 0)
//     clr  in   synchronous clear; the counter reads 0 the next cycle
//     en   in   count enable
//     cnt  out  current count
//     sat  out  high while cnt is all-ones
//
//   clr wins over en, so a restart on a saturated counter always works.
// -----------------------------------------------------------------------------
module sat_counter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W = PM_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + CNT_ONE;
        end
    end

    assign cnt = cnt_reg;
    assign sat = (cnt_reg == CNT_MAX);

endmodule : sat_counter

// File: rtl/pulse_meter.sv
// -----------------------------------------------------------------------------
// pulse_meter
//   Measures high time and period of a synchronized pulse train, in clk
//   cycles, from the one-cycle rise/fall strobes of an upstream edge detector.
//   A finished measurement is held behind a valid/ready handshake.
//
//   Ports:
//     clk        in   system clock, all logic on posedge
//     rst        in   synchronous active-high reset
//     rise       in   one-cycle strobe, rising edge of the input
//     fall       in   one-cycle strobe, falling edge of the input
//     meas_valid out  high_time/period hold a completed measurement
//     meas_ready in   consumer takes the measurement when valid & ready
//     high_time  out  cycles from rise strobe to fall strobe
//     period     out  cycles from rise strobe to the next rise strobe
//     overrun    out  sticky, a result was dropped while one was pending;
//                     cleared by a transfer
//     timeout    out  sticky, the counter saturated with no closing edge;
//                     cleared by the next accepted rise
//
//   Timing model: the counter is cleared by an accepted rise, so in the cycle
//   k cycles after that rise it reads k-1. The elapsed time in the current
//   cycle is therefore cnt+1. Saturation (cnt all-ones) is checked before
//   any edge, which keeps every reported elapsed value representable.
// -----------------------------------------------------------------------------
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W = PM_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rise,
    input  logic             fall,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             overrun,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    pm_state_t        state_reg;
    logic [CNT_W-1:0] hi_tmp_reg;
    logic [CNT_W-1:0] high_time_reg;
    logic [CNT_W-1:0] period_reg;
    logic             meas_valid_reg;
    logic             overrun_reg;
    logic             timeout_reg;

    // ------------------------------------------------------------------
    // Counter interface
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic             cnt_sat;
    logic             cnt_clr;
    logic [CNT_W-1:0] elapsed;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic edge_rise;    // rise alone; simultaneous rise+fall is discarded
    logic edge_fall;    // fall alone
    logic in_meas;      // HIGH or LOW, i.e. a measurement is running
    logic meas_done;    // closing rise seen in LOW
    logic xfer;         // consumer takes the held result this cycle
    logic load;         // new result goes into the output registers
    logic drop;         // new result discarded because the slot is busy

    assign edge_rise = rise & ~fall;
    assign edge_fall = fall & ~rise;
    assign in_meas   = (state_reg == PM_HIGH) || (state_reg == PM_LOW);

    // Saturation in a running measurement turns into a timeout, so an edge
    // on that same cycle is not accepted and must not restart the counter.
    assign cnt_clr   = edge_rise && ((state_reg == PM_IDLE) || (in_meas && !cnt_sat));

    assign elapsed   = cnt + CNT_ONE;

    assign meas_done = (state_reg == PM_LOW) && !cnt_sat && edge_rise;
    assign xfer      = meas_valid_reg && meas_ready;
    // The output slot is free if empty or being emptied on this very cycle.
    assign load      = meas_done && (!meas_valid_reg || meas_ready);
    assign drop      = meas_done && !load;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (1'b1),
        .cnt (cnt),
        .sat (cnt_sat)
    );

    // ------------------------------------------------------------------
    // FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= PM_IDLE;
            hi_tmp_reg     <= '0;
            high_time_reg  <= '0;
            period_reg     <= '0;
            meas_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            case (state_reg)
                PM_IDLE: begin
                    // A fall with no preceding rise carries no information.
                    if (edge_rise) begin
                        state_reg   <= PM_HIGH;
                        timeout_reg <= 1'b0;
                    end
                end

                PM_HIGH: begin
                    if (cnt_sat) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= PM_IDLE;
                    end else if (edge_fall) begin
                        hi_tmp_reg <= elapsed;
                        state_reg  <= PM_LOW;
                    end
                    // A second rise means the fall was missed; the counter
                    // restarts via cnt_clr and the state stays HIGH.
                end

                PM_LOW: begin
                    if (cnt_sat) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= PM_IDLE;
                    end else if (edge_rise) begin
                        // Closing rise is also the opening rise of the next
                        // measurement, so back-to-back periods need no gap.
                        state_reg <= PM_HIGH;
                    end
                end

                default: begin
                    state_reg <= PM_IDLE;
                end
            endcase

            // Output slot: load wins over the transfer-driven clear.
            if (load) begin
                high_time_reg  <= hi_tmp_reg;
                period_reg     <= elapsed;
                meas_valid_reg <= 1'b1;
            end else if (xfer) begin
                meas_valid_reg <= 1'b0;
            end

            // drop and xfer are mutually exclusive: a transfer frees the slot.
            if (drop) begin
                overrun_reg <= 1'b1;
            end else if (xfer) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign meas_valid = meas_valid_reg;
    assign high_time  = high_time_reg;
    assign period     = period_reg;
    assign overrun    = overrun_reg;
    assign timeout    = timeout_reg;

endmodule : pulse_meter
